mkio_word_rx: RTL and testbench

//  MIL-STD-1553B Manchester-II word decoder for one bus channel (A or B); instantiated once per channel in mkio.

---
 rtl/mkio_pkg.sv | 43 ++++
 rtl/mkio_line_sync.sv | 35 +++
 rtl/mkio_word_rx.sv | 206 ++++++++++++++++++++
 tb/tb_mkio_word_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// Shared types and constants for the MIL-STD-1553B Manchester-II word receiver:
// line-state codes, receiver FSM states, error codes and sync-word values.
package mkio_pkg;

  // Decoded differential line state after synchronisation.
  typedef enum logic [1:0] {
    LINE_Z = 2'b00,   // idle / invalid ({0,0} or {1,1})
    LINE_N = 2'b01,   // di1=0, di0=1
    LINE_P = 2'b10    // di1=1, di0=0
  } line_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC1,
    ST_SYNC2,
    ST_DATA
  } rx_state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_LINE   = 2'b01;
  localparam logic [1:0] ERR_PARITY = 2'b10;
  localparam logic [1:0] ERR_SYNC   = 2'b11;

  // rx_sync values: command/status sync is + then -, data sync is - then +.
  localparam logic SYNC_CMD  = 1'b1;
  localparam logic SYNC_DATA = 1'b0;

  // 16 data bits plus the odd-parity bit.
  localparam int NUM_BITS = 17;

  // Window (clocks) around the nominal mid-bit edge accepted for realignment.
  localparam int RESYNC_WIN = 4;

  // Map the two transceiver lines onto a line state; both equal means invalid.
  function automatic line_e decode_line(input logic d1, input logic d0);
    line_e ls;
    ls = LINE_Z;
    if (d1 && !d0) ls = LINE_P;
    else if (!d1 && d0) ls = LINE_N;
    return ls;
  endfunction

endpackage

// File: rtl/mkio_line_sync.sv
// Two-flop synchroniser for the asynchronous di1/di0 receiver lines followed by
// P/N/Z line-state decode. One instance per bus channel.
module mkio_line_sync
  import mkio_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  di1,
  input  logic  di0,
  output line_e line_state
);

  logic [1:0] meta_q;
  logic [1:0] stab_q;

  // Two register stages absorb metastability before the lines are used.
  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // the values from before the clock edge and the chain really is two deep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 2'b00;
      stab_q <= 2'b00;
    end else begin
      meta_q <= {di1, di0};
      stab_q <= meta_q;
    end
  end

  // Decode the stable pair into a line state.
  // NOTE: the output is fully assigned on every path, so no latch is inferred.
  always_comb begin
    line_state = decode_line(stab_q[1], stab_q[0]);
  end

endmodule

// File: rtl/mkio_word_rx.sv
// MIL-STD-1553B Manchester-II word decoder for one bus channel.
// Detects command/status or data sync, decodes 16 data bits plus odd parity and
// reports each word as a one-cycle rx_valid or rx_err strobe with an error code.
// Optional feature macro: MKIO_RX_RESYNC_EN -- when defined, mid-bit transitions
// near their nominal position realign the bit timer; otherwise the bit timer
// free-runs from the sync mid transition.
module mkio_word_rx
  import mkio_pkg::*;
#(
  parameter int HALF_BIT = 16,
  parameter int SYNC_TOL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_en,
  input  logic        di1,
  input  logic        di0,
  output logic [15:0] rx_data,
  output logic        rx_sync,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [1:0]  err_code,
  output logic        rx_busy
);

  localparam int SYNC_NOM = 3 * HALF_BIT;
  localparam int CW       = $clog2(SYNC_NOM + SYNC_TOL + 1);

  localparam logic [CW-1:0] SYNC_MIN  = CW'(SYNC_NOM - SYNC_TOL);
  localparam logic [CW-1:0] SYNC_MAX  = CW'(SYNC_NOM + SYNC_TOL);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_NOM - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * HALF_BIT - 1);
  localparam logic [CW-1:0] SAMP_A    = CW'(HALF_BIT / 2);
  localparam logic [CW-1:0] SAMP_B    = CW'(HALF_BIT + HALF_BIT / 2);
  localparam logic [4:0]    WORD_END  = 5'(NUM_BITS);

  line_e          ls;          // current synchronised line state
  line_e          ls_prev;     // line state one cycle earlier
  line_e          level;       // level being timed in SYNC1 / SYNC2
  line_e          a_lvl;       // first-half sample of the current bit
  rx_state_e      state;
  logic [CW-1:0]  cnt;         // SYNC1: run length; SYNC2: t; DATA: phase in bit
  logic [CW-1:0]  phase_next;
  logic [4:0]     bit_cnt;     // DATA: bit index, 16 = parity, 17 = word end
  logic [16:0]    shreg;       // data bits MSB first, parity in bit 0
  logic           sync_type;

  mkio_line_sync u_line_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .di1        (di1),
    .di0        (di0),
    .line_state (ls)
  );

`ifdef MKIO_RX_RESYNC_EN
  localparam logic [CW-1:0] MID_LO   = CW'(HALF_BIT - RESYNC_WIN);
  localparam logic [CW-1:0] MID_HI   = CW'(HALF_BIT + RESYNC_WIN);
  localparam logic [CW-1:0] MID_NEXT = CW'(HALF_BIT + 1);

  logic mid_edge;
  assign mid_edge = (ls != ls_prev) && (ls != LINE_Z) && (ls_prev != LINE_Z);

  // Next bit phase; a mid-bit edge near nominal pins this cycle to the mid point.
  always_comb begin
    phase_next = (cnt == BIT_LAST) ? '0 : cnt + 1'b1;
    if (mid_edge && (cnt >= MID_LO) && (cnt <= MID_HI)) phase_next = MID_NEXT;
  end
`else
  // Next bit phase; the timer free-runs from the sync mid transition.
  always_comb begin
    phase_next = (cnt == BIT_LAST) ? '0 : cnt + 1'b1;
  end
`endif

  // Receiver FSM: sync timing, bit sampling, parity and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ls_prev   <= LINE_Z;
      level     <= LINE_Z;
      a_lvl     <= LINE_Z;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      sync_type <= 1'b0;
      rx_data   <= '0;
      rx_sync   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      err_code  <= ERR_NONE;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      ls_prev  <= ls;

      if (!rx_en) begin
        state   <= ST_IDLE;
        rx_busy <= 1'b0;
        cnt     <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if ((ls_prev == LINE_Z) && (ls != LINE_Z)) begin
              level   <= ls;
              cnt     <= CW'(1);
              state   <= ST_SYNC1;
              rx_busy <= 1'b1;
            end
          end

          ST_SYNC1: begin
            if (ls == level) begin
              if (cnt >= SYNC_MAX) begin
                rx_err   <= 1'b1;
                err_code <= ERR_SYNC;
                rx_busy  <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                cnt     <= cnt + 1'b1;
                rx_busy <= 1'b1;
              end
            end else if ((ls != LINE_Z) && (cnt >= SYNC_MIN)) begin
              // First half ended in range; this cycle is t=0 of the second half.
              sync_type <= (level == LINE_P) ? SYNC_CMD : SYNC_DATA;
              level     <= ls;
              cnt       <= CW'(1);
              state     <= ST_SYNC2;
              rx_busy   <= 1'b1;
            end else begin
              rx_err   <= 1'b1;
              err_code <= ERR_SYNC;
              rx_busy  <= 1'b0;
              state    <= ST_IDLE;
            end
          end

          ST_SYNC2: begin
            if ((ls == LINE_Z) || ((ls != level) && (cnt < SYNC_MIN))) begin
              rx_err   <= 1'b1;
              err_code <= ERR_SYNC;
              rx_busy  <= 1'b0;
              state    <= ST_IDLE;
            end else if (cnt == SYNC_LAST) begin
              cnt     <= '0;
              bit_cnt <= '0;
              state   <= ST_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_DATA: begin
            if (bit_cnt == WORD_END) begin
              // t=592: report the word, then chain straight into the next sync.
              rx_busy <= 1'b0;
              bit_cnt <= '0;
              if (^shreg) begin
                rx_valid <= 1'b1;
                rx_data  <= shreg[16:1];
                rx_sync  <= sync_type;
                err_code <= ERR_NONE;
              end else begin
                rx_err   <= 1'b1;
                err_code <= ERR_PARITY;
              end
              if (ls != LINE_Z) begin
                level <= ls;
                cnt   <= '0;
                state <= ST_SYNC1;
              end else begin
                cnt   <= '0;
                state <= ST_IDLE;
              end
            end else begin
              cnt <= phase_next;
              if (cnt == BIT_LAST) bit_cnt <= bit_cnt + 5'd1;
              if (cnt == SAMP_A) a_lvl <= ls;
              if (cnt == SAMP_B) begin
                if ((a_lvl == LINE_P) && (ls == LINE_N)) begin
                  shreg <= {shreg[15:0], 1'b1};
                end else if ((a_lvl == LINE_N) && (ls == LINE_P)) begin
                  shreg <= {shreg[15:0], 1'b0};
                end else begin
                  rx_err   <= 1'b1;
                  err_code <= ERR_LINE;
                  rx_busy  <= 1'b0;
                  cnt      <= '0;
                  state    <= ST_IDLE;
                end
              end
            end
          end

          default: begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mkio_word_rx.sv
// Self-checking bench for mkio_word_rx: directed 1553 word scenarios followed by
// randomized words, checked against a word-level outcome model.
module tb_mkio_word_rx;
  import mkio_pkg::*;

  localparam int H        = 16;
  localparam int TOL      = 8;
  localparam int WORD_CLK = 40 * H;   // 3H + 3H + 17 * 2H

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_en;
  logic        di1;
  logic        di0;
  logic [15:0] rx_data;
  logic        rx_sync;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  err_code;
  logic        rx_busy;

  mkio_word_rx #(.HALF_BIT(H), .SYNC_TOL(TOL)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_en    (rx_en),
    .di1      (di1),
    .di0      (di0),
    .rx_data  (rx_data),
    .rx_sync  (rx_sync),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outcome of one transmitted word.
  typedef struct {
    bit          valid;
    logic [15:0] data;
    bit          sync;
    logic [1:0]  code;
    bit          contig;
  } exp_t;

  // Description of one word put on the bus.
  typedef struct {
    bit          cmd;
    logic [15:0] data;
    bit          par_flip;
    int          bad_bit;   // bit held P for a full bit time, -1 = none
    int          sync1;     // clocks of the first sync half
    int          en_drop;   // bit at which rx_en drops, -1 = never
    int          rst_at;    // bit at which reset_n asserts, -1 = never
    bit          contig;    // follows the previous word with no gap
  } word_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_code = '0;
  int unsigned last_valid_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic word_t mk(input bit cmd, input logic [15:0] d);
    word_t w;
    w.cmd = cmd; w.data = d; w.par_flip = 0; w.bad_bit = -1;
    w.sync1 = 3 * H; w.en_drop = -1; w.rst_at = -1; w.contig = 0;
    return w;
  endfunction

  // First-half length as the decoder times it: a chained word starts at run 0.
  function automatic int eff_run(input word_t w);
    return w.contig ? w.sync1 - 1 : w.sync1;
  endfunction

  function automatic bit sync_bad(input word_t w);
    return (eff_run(w) < 3 * H - TOL) || (eff_run(w) > 3 * H + TOL);
  endfunction

  // Outcome model: sync length, then Manchester validity, then odd parity.
  function automatic void predict(input word_t w);
    exp_t e;
    e.valid = 0; e.data = w.data; e.sync = w.cmd; e.contig = w.contig;
    if (w.en_drop >= 0 || w.rst_at >= 0) return;
    if (sync_bad(w))           e.code = 2'b11;
    else if (w.bad_bit >= 0)   e.code = 2'b01;
    else if (w.par_flip)       e.code = 2'b10;
    else begin e.valid = 1;    e.code = 2'b00; end
    exp_q.push_back(e);
  endfunction

  // lvl: 1 = P, -1 = N, 0 = Z as {0,0}, 2 = Z as {1,1}
  task automatic drive(input int lvl, input int n);
    case (lvl)
      1:       {di1, di0} = 2'b10;
      -1:      {di1, di0} = 2'b01;
      2:       {di1, di0} = 2'b11;
      default: {di1, di0} = 2'b00;
    endcase
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input word_t w);
    int          first;
    logic        p;
    logic [16:0] bits;
    bit          exp_busy;
    first    = w.cmd ? 1 : -1;
    p        = (~^w.data) ^ w.par_flip;
    bits     = {w.data, p};
    exp_busy = !sync_bad(w) && !(w.bad_bit >= 0 && w.bad_bit < 8);
    predict(w);
    drive(first, w.sync1);
    drive(-first, 3 * H);
    for (int k = 0; k < NUM_BITS; k++) begin
      if (k == w.en_drop) rx_en = 1'b0;
      if (k == w.rst_at) reset_n = 1'b0;
      if (k == 8 && w.en_drop < 0 && w.rst_at < 0) check("busy_mid", rx_busy, exp_busy);
      if (k == w.bad_bit)   drive(1, 2 * H);
      else if (bits[16-k]) begin drive(1, H);  drive(-1, H); end
      else                 begin drive(-1, H); drive(1, H);  end
      if (k == w.en_drop) begin
        check("en_busy", rx_busy, 0);
        check("en_data_kept", rx_data, last_data);
      end
      if (k == w.rst_at) begin
        check("rst_data", rx_data, 0);
        check("rst_code", err_code, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_sync", rx_sync, 0);
      end
    end
  endtask

  // Idle gap, then confirm the last word's data and error code are still held.
  task automatic gap(input int n);
    drive(($urandom_range(0, 1) == 0) ? 0 : 2, n);
    check("data_hold", rx_data, last_data);
    check("code_hold", err_code, last_code);
  endtask

  // Strobe monitor: pairs every strobe with the oldest expected outcome.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      last_data = '0;
      last_code = '0;
    end else if (rx_valid || rx_err) begin
      if (exp_q.size() == 0) begin
        check("unexp_strobe", {rx_valid, rx_err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", {rx_valid, rx_err}, e.valid ? 2'b10 : 2'b01);
        check("err_code", err_code, e.code);
        if (e.valid) begin
          check("rx_data", rx_data, e.data);
          check("rx_sync", rx_sync, e.sync);
          if (e.contig) check("spacing", cyc - last_valid_cyc, WORD_CLK);
          last_valid_cyc = cyc;
          last_data = e.data;
        end
        last_code = e.code;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    int    kind;
    int    sync_opts[5] = '{30, 36, 42, 54, 60};
    reset_n = 1'b0;
    rx_en   = 1'b1;
    {di1, di0} = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_data",  rx_data,  0);
    check("reset_sync",  rx_sync,  0);
    check("reset_valid", rx_valid, 0);
    check("reset_err",   rx_err,   0);
    check("reset_code",  err_code, 0);
    check("reset_busy",  rx_busy,  0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Command word RT1 rx SA3 WC7.
    send(mk(1, 16'h0867)); gap(20);

    // Command followed gaplessly by seven data words.
    send(mk(1, 16'(($urandom))));
    for (int i = 0; i < 7; i++) begin
      w = mk(0, 16'($urandom)); w.contig = 1; send(w);
    end
    gap(20);

    // Inverted parity.
    w = mk(0, 16'hA5A5); w.par_flip = 1; send(w); gap(20);

    // Bit 5 held P for a full bit.
    w = mk(1, 16'($urandom)); w.bad_bit = 5; send(w); gap(20);

    // Short first sync half, then a good word.
    w = mk(1, 16'($urandom)); w.sync1 = 30; send(w); gap(20);
    send(mk(0, 16'($urandom))); gap(20);

    // Sync tolerance boundaries.
    w = mk(1, 16'($urandom)); w.sync1 = 3 * H - TOL;     send(w); gap(16);
    w = mk(0, 16'($urandom)); w.sync1 = 3 * H + TOL;     send(w); gap(16);
    w = mk(1, 16'($urandom)); w.sync1 = 3 * H - TOL - 1; send(w); gap(16);
    w = mk(0, 16'($urandom)); w.sync1 = 3 * H + TOL + 1; send(w); gap(16);

    // Reset mid-word, released during the following idle gap.
    w = mk(1, 16'($urandom)); w.rst_at = 8; send(w);
    drive(0, 10);
    reset_n = 1'b1;
    gap(20);

    // rx_en dropped mid-word, restored during the idle gap.
    w = mk(0, 16'($urandom)); w.en_drop = 3; send(w);
    drive(0, 10);
    rx_en = 1'b1;
    gap(20);
    send(mk(1, 16'($urandom))); gap(20);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      w = mk(1'($urandom_range(0, 1)), 16'($urandom));
      case (kind)
        5: w.par_flip = 1;
        6: w.bad_bit  = $urandom_range(0, 16);
        7: w.sync1    = sync_opts[$urandom_range(0, 4)];
        default: ;
      endcase
      send(w);
      if (kind == 8) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          w = mk(1'($urandom_range(0, 1)), 16'($urandom)); w.contig = 1; send(w);
        end
      end
      gap($urandom_range(8, 40));
    end

    repeat (50) @(negedge clk);
    check("missing_strobes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
